// File: rtl/cipher_stream_engine.sv
// Stream decryption engine: captures a master word, serialises it MSB-first into
// symbols, decrypts each symbol and queues it in a show-ahead ready/valid FIFO.
module cipher_stream_engine #(
  parameter int unsigned MST_DWIDTH = 32,
  parameter int unsigned SYS_DWIDTH = 8,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  busy,
  input  logic [1:0]            mode_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  output logic [SYS_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [15:0]           sym_count_o,
  output logic [7:0]            drop_count_o
);

  localparam int unsigned LANES  = MST_DWIDTH / SYS_DWIDTH;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SERIAL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [MST_DWIDTH-1:0] r_word;
  logic [1:0]            r_mode;
  logic [SYS_DWIDTH-1:0] r_key;
  logic [LANE_W-1:0]     r_lane;
  logic [15:0]           r_n;
  logic [1:0]            r_prev_mode;
  logic [SYS_DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [15:0]           r_sym_count;
  logic [7:0]            r_drop_count;

  logic                  w_capture;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_lane;
  logic                  w_drop;
  logic [MST_DWIDTH-1:0] w_shifted;
  logic [SYS_DWIDTH-1:0] w_lane;
  logic [SYS_DWIDTH-1:0] w_dec;
  logic                  w_unused_key;

  assign w_unused_key = ^key_i[KEY_WIDTH-1:SYS_DWIDTH];

  assign w_capture   = (r_state == S_IDLE) && valid_i;
  assign w_drop      = (r_state == S_SERIAL) && valid_i;
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = (r_state == S_SERIAL) && !w_full;
  assign w_pop       = (r_count != '0) && ready_i;
  assign w_last_lane = (r_lane == LANE_W'(LANES - 1));

  assign busy        = (r_state == S_SERIAL);
  assign valid_o     = (r_count != '0);
  assign data_o      = r_mem[r_rd_ptr];
  assign sym_count_o  = r_sym_count;
  assign drop_count_o = r_drop_count;

  // MSB-first lane select: shift the current lane up to the top of the word.
  assign w_shifted = r_word << (r_lane * SYS_DWIDTH);
  assign w_lane    = w_shifted[MST_DWIDTH-1 -: SYS_DWIDTH];

  always_comb begin
    w_dec = w_lane;
    case (r_mode)
      2'd0:    w_dec = w_lane - r_key;
      2'd1:    w_dec = w_lane ^ r_key;
      2'd2:    w_dec = w_lane - (r_key + r_n[SYS_DWIDTH-1:0]);
      default: w_dec = w_lane;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (valid_i) w_next_state = S_SERIAL;
      S_SERIAL: if (w_push && w_last_lane) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Word capture, lane sequencing and rolling-key counter.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_word      <= '0;
      r_mode      <= '0;
      r_key       <= '0;
      r_lane      <= '0;
      r_n         <= '0;
      r_prev_mode <= '0;
    end else if (w_capture) begin
      r_word      <= data_i;
      r_mode      <= mode_i;
      r_key       <= key_i[SYS_DWIDTH-1:0];
      r_lane      <= '0;
      r_prev_mode <= mode_i;
      if (mode_i != r_prev_mode) r_n <= '0;
    end else if (w_push) begin
      r_lane <= r_lane + LANE_W'(1);
      if (r_mode == 2'd2) r_n <= r_n + 16'd1;
    end
  end

  // Output FIFO; a pop in a full cycle frees the slot only on the next cycle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_sym_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_pop) r_sym_count <= r_sym_count + 16'd1;
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cipher_stream_engine.sv
// Directed bench for cipher_stream_engine with a scoreboard of expected symbols.
module tb_cipher_stream_engine;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        valid_i;
  logic        busy;
  logic [1:0]  mode_i;
  logic [15:0] key_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] sym_count_o;
  logic [7:0]  drop_count_o;

  int          checks = 0;
  int          errors = 0;
  int          exp_sym = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] m_n = 16'd0;
  logic [1:0]  m_prev = 2'd0;

  always #5 clk_sys = ~clk_sys;

  cipher_stream_engine #(
    .MST_DWIDTH(32), .SYS_DWIDTH(8), .KEY_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .busy         (busy),
    .mode_i       (mode_i),
    .key_i        (key_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .sym_count_o  (sym_count_o),
    .drop_count_o (drop_count_o)
  );

  function automatic logic [7:0] model_dec(input logic [7:0] d, input logic [7:0] k,
                                           input logic [1:0] m, input logic [15:0] n);
    logic [7:0] kn;
    kn = k + n[7:0];
    case (m)
      2'd0:    return d - k;
      2'd1:    return d ^ k;
      2'd2:    return d - kn;
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'(0));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 400) begin
      step();
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'(0));
    chk("drain_valid", 32'(valid_o), 32'(0));
  endtask

  // Drive one word while idle; expected symbols enter the scoreboard here.
  task automatic send_word(input logic [31:0] data, input logic [1:0] mode, input logic [15:0] key);
    logic [31:0] tmp;
    wait_idle();
    if (mode != m_prev) m_n = 16'd0;
    m_prev = mode;
    for (int i = 0; i < 4; i++) begin
      tmp = data >> (24 - 8 * i);
      exp_q.push_back(model_dec(tmp[7:0], key[7:0], mode, m_n));
      if (mode == 2'd2) m_n = m_n + 16'd1;
    end
    data_i  = data;
    mode_i  = mode;
    key_i   = key;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    mode_i  = mode + 2'd1;
    key_i   = ~key;
    chk("busy_after_capture", 32'(busy), 32'(1));
  endtask

  always @(negedge clk_sys) begin
    logic [7:0] e;
    if (!rst && valid_o && ready_i) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_symbol: observed %0h expected none", data_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        assert (data_o === e) else begin
          errors++;
          $error("FAIL symbol: observed %0h expected %0h", data_o, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 1'b0; mode_i = '0; key_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(valid_o), 32'(0));
    chk("rst_data", 32'(data_o), 32'(0));
    chk("rst_sym", 32'(sym_count_o), 32'(0));
    chk("rst_drop", 32'(drop_count_o), 32'(0));
    rst = 1'b0;
    step();

    // Caesar: latency, busy duration, symbol count
    send_word(32'h4B484F4F, 2'd0, 16'd3);
    chk("latency_valid_e0", 32'(valid_o), 32'(0));
    step();
    chk("latency_valid_e1", 32'(valid_o), 32'(1));
    chk("latency_data_e1", 32'(data_o), 32'h48);
    step();
    chk("busy_e2", 32'(busy), 32'(1));
    step();
    chk("busy_e3", 32'(busy), 32'(1));
    step();
    chk("busy_e4", 32'(busy), 32'(0));
    wait_drain();
    exp_sym += 4;
    chk("sym_caesar", 32'(sym_count_o), 32'(exp_sym));

    // XOR then bypass
    send_word(32'h00FF55AA, 2'd1, 16'h00FF);
    send_word(32'h01020304, 2'd3, 16'h1234);
    wait_drain();
    exp_sym += 8;
    chk("sym_xor_bypass", 32'(sym_count_o), 32'(exp_sym));

    // Rolling Caesar, counter persistence and restart
    send_word(32'h02030405, 2'd2, 16'd1);
    send_word(32'h02030405, 2'd2, 16'd1);
    send_word(32'h10203040, 2'd0, 16'h0010);
    send_word(32'h02030405, 2'd2, 16'd1);
    wait_drain();
    exp_sym += 16;
    chk("sym_rolling", 32'(sym_count_o), 32'(exp_sym));

    // Backpressure: first word fills FIFO, second stalls in SERIAL
    ready_i = 1'b0;
    send_word(32'hA1A2A3A4, 2'd3, 16'd0);
    send_word(32'hB1B2B3B4, 2'd0, 16'd1);
    repeat (5) step();
    chk("bp_busy", 32'(busy), 32'(1));
    chk("bp_valid", 32'(valid_o), 32'(1));
    chk("bp_head", 32'(data_o), 32'hA1);
    ready_i = 1'b1;
    wait_drain();
    exp_sym += 8;
    chk("sym_backpressure", 32'(sym_count_o), 32'(exp_sym));

    // Drop while busy, then saturation
    send_word(32'h11223344, 2'd3, 16'd0);
    data_i  = 32'hDEADBEEF;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("drop_one", 32'(drop_count_o), 32'(1));
    wait_drain();
    exp_sym += 4;
    chk("sym_drop", 32'(sym_count_o), 32'(exp_sym));
    ready_i = 1'b0;
    send_word(32'h55667788, 2'd3, 16'd0);
    send_word(32'h99AABBCC, 2'd3, 16'd0);
    data_i  = 32'hDEADBEEF;
    valid_i = 1'b1;
    repeat (300) step();
    valid_i = 1'b0;
    chk("drop_saturate", 32'(drop_count_o), 32'd255);
    chk("drop_busy_held", 32'(busy), 32'(1));
    ready_i = 1'b1;
    wait_drain();
    exp_sym += 8;
    chk("sym_after_drops", 32'(sym_count_o), 32'(exp_sym));

    // Asynchronous reset after lane 1 is pushed
    send_word(32'h4B484F4F, 2'd0, 16'd3);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_valid", 32'(valid_o), 32'(0));
    chk("arst_data", 32'(data_o), 32'(0));
    chk("arst_sym", 32'(sym_count_o), 32'(0));
    chk("arst_drop", 32'(drop_count_o), 32'(0));
    exp_q.delete();
    m_n = 16'd0;
    m_prev = 2'd0;
    exp_sym = 0;
    step();
    rst = 1'b0;
    step();
    send_word(32'h4B484F4F, 2'd0, 16'd3);
    step();
    chk("post_rst_valid", 32'(valid_o), 32'(1));
    wait_drain();
    exp_sym += 4;
    chk("sym_post_rst", 32'(sym_count_o), 32'(exp_sym));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cipher_stream_engine.md
# cipher_stream_engine

Single-clock, parametrised successor to the three-way decryption top. It accepts MST_DWIDTH-bit words from the master side and serialises each into LANES = MST_DWIDTH/SYS_DWIDTH symbols. Each symbol is decrypted in one of four run-time modes (Caesar, XOR, rolling Caesar, bypass) and buffered in an output FIFO with a downstream ready/valid handshake. It replaces the demux → cipher → mux chain for stream ciphers and adds backpressure, drop accounting and delivered-symbol counting.

## Interface
- MST_DWIDTH, 32, input word width; integer multiple of SYS_DWIDTH
- SYS_DWIDTH, 8, symbol width
- KEY_WIDTH, 16, key port width; only bits [SYS_DWIDTH-1:0] are used
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2
- clk_sys  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_i  in  MST_DWIDTH  input word
- valid_i  in  1  word present
- busy  out  1  high while a captured word is still being serialised
- mode_i  in  2  0 Caesar, 1 XOR, 2 rolling Caesar, 3 bypass
- key_i  in  KEY_WIDTH  decryption key
- data_o  out  SYS_DWIDTH  FIFO head symbol
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  downstream accepts the symbol
- sym_count_o  out  16  symbols delivered (valid_o && ready_i); wraps at 2^16
- drop_count_o  out  8  words offered while busy; saturates at 255

## Operation
- States: IDLE and SERIAL. busy = (state==SERIAL), combinational from the state register.
- IDLE: if valid_i, latch data_i, mode_i and key_i[SYS_DWIDTH-1:0], set lane=0 and go to SERIAL. Mode and key changes after capture do not affect that word.
- SERIAL: in each cycle with FIFO count < FIFO_DEPTH, push the decrypted lane and increment lane. On the push of lane LANES-1, go to IDLE. When the FIFO is full, stall without pushing. A simultaneous pop does not free the slot in the same cycle.
- Lane order is MSB-first: lane i = word[MST_DWIDTH-1-i·SYS_DWIDTH -: SYS_DWIDTH].
- Decrypt (d = lane, k = latched key, all arithmetic mod 2^SYS_DWIDTH):
  - mode 0: d − k
  - mode 1: d ^ k
  - mode 2: d − (k + n)
  - mode 3: d
- Rolling counter n (16-bit, truncated to SYS_DWIDTH in use):
  - increments on every mode-2 push;
  - clears when a word is captured whose mode ≠ previously captured mode;
  - otherwise persists across words.
- valid_i while busy: the word is discarded, drop_count_o increments (saturating), and state is unaffected.
- FIFO is show-ahead: data_o = mem[rd_ptr]. Pop on valid_o && ready_i, which also increments sym_count_o. Push and pop may occur in the same cycle when not full.
- Reset (asynchronous, any time):
  - state IDLE, FIFO empty, partial word discarded;
  - n = 0, previous mode = 0;
  - busy, data_o, valid_o, sym_count_o, drop_count_o = 0.

## Timing
- Capture at edge E0 (valid_i high, busy low). busy is high after E0.
- With no stall, lane 0 is pushed at E1, so valid_o and data_o show lane 0 after E1. Latency is two edges from valid_i to valid_o.
- Lanes are pushed at E1..E_LANES. busy falls after E_LANES, and the next word can be captured at E_LANES+1. Peak input rate is one word per LANES+1 cycles; output rate is one symbol per cycle.
- Each FIFO-full cycle adds one cycle to busy.
- ready_i is combinationally sampled. data_o is stable while valid_o && !ready_i.
- Counters update on the same edge as the event they count.

## Test plan
- Caesar: mode 0, key 3, data_i 32'h4B484F4F → data_o 48, 45, 4C, 4C on four consecutive cycles. busy is high for 4 cycles, then sym_count_o = 4.
- XOR + bypass: mode 1, key 16'h00FF, word 32'h00FF55AA → FF, 00, AA, 55. Then mode 3, word 32'h01020304 → 01, 02, 03, 04.
- Rolling: mode 2, key 1, word 32'h02030405 twice → 01 01 01 01, then FD FD FD FD. Then a mode-0 word and another mode-2 word → the counter restarts at n=0.
- Backpressure: ready_i=0, FIFO_DEPTH=4, two words sent. The first word fills the FIFO. The second is captured, but busy stays high and nothing is pushed. Raise ready_i → all 8 symbols delivered in order, sym_count_o = 8, no loss.
- Drop: assert valid_i with 32'hDEADBEEF while busy → the word never appears, drop_count_o = 1. Offer 300 such words → drop_count_o = 255.
- Reset mid-word: assert rst after lane 1 is pushed → all outputs are 0 immediately and the FIFO is empty. After release, a fresh word decodes correctly from lane 0.
